// File: rtl/spi_ctrl_pkg.sv
// Shared types for the SPI frame sequencer.
// Provides the FSM state enum and the shifter watchdog limits.
package spi_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    STORE,
    GAP
  } state_t;

  localparam int TMO_W   = 8;
  localparam int TMO_MAX = 2**TMO_W - 1;
endpackage

// File: rtl/spi_dcnt.sv
// Loadable down-counter, saturating at zero.
// Ports: clk, rst_n, ld/ld_val (load), dec (count down), last (count <= 1).
module spi_dcnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic         dec,
  input  logic [W-1:0] ld_val,
  output logic         last
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // treat an empty counter as terminal too, so the FSM cannot stall
  assign last = (cnt <= W'(1));
endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI frame sequencer: TX FIFO -> shifter -> RX FIFO, with slave select,
// inter-frame gap and shifter watchdog. All outputs are registered.
module spi_xfer_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int N          = $clog2(FIFO_DEPTH + 1),
  parameter int DATA_W     = 8,
  parameter int GAP_W      = 4
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              en,
  input  logic [GAP_W-1:0]  gap_cfg,
  input  logic [N-1:0]      tx_cnt,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_pop,
  input  logic [N-1:0]      rx_cnt,
  output logic              rx_push,
  output logic [DATA_W-1:0] rx_data,
  output logic              shf_start,
  output logic [DATA_W-1:0] shf_data,
  input  logic              shf_done,
  input  logic [DATA_W-1:0] shf_rdata,
  output logic              ss_n,
  output logic              busy,
  output logic              err
);
  localparam logic [N-1:0] RX_FULL = N'(FIFO_DEPTH);
  localparam logic [N-1:0] RX_LIM  = N'(FIFO_DEPTH - 2);
  localparam logic [TMO_W-1:0] WD_MAX = TMO_W'(TMO_MAX);
  localparam logic [TMO_W-1:0] WD_EXP = WD_MAX - 1'b1;

  state_t           state;
  logic [TMO_W-1:0] wd;
  logic             go;
  logic             cont;
  logic             gap_ld;
  logic             gap_dec;
  logic             gap_last;

  assign go = en && tx_cnt != '0 && rx_cnt < RX_FULL;
  // at STORE the RX count does not yet include the push in flight
  assign cont = en && tx_cnt != '0 && rx_cnt <= RX_LIM;

  assign gap_ld  = (state == STORE) && cont && gap_cfg != '0;
  assign gap_dec = (state == GAP);

  spi_dcnt #(.W(GAP_W)) u_gap (
    .clk    (PCLK),
    .rst_n  (PRESETn),
    .ld     (gap_ld),
    .dec    (gap_dec),
    .ld_val (gap_cfg),
    .last   (gap_last)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      wd        <= '0;
      tx_pop    <= 1'b0;
      rx_push   <= 1'b0;
      rx_data   <= '0;
      shf_start <= 1'b0;
      shf_data  <= '0;
      ss_n      <= 1'b1;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      tx_pop    <= 1'b0;
      rx_push   <= 1'b0;
      shf_start <= 1'b0;
      err       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            state    <= LOAD;
            tx_pop   <= 1'b1;
            shf_data <= tx_data;
            ss_n     <= 1'b0;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          state     <= SHIFT;
          shf_start <= 1'b1;
          wd        <= '0;
        end
        SHIFT: begin
          if (wd != WD_MAX) wd <= wd + 1'b1;
          // a completion on the expiry cycle still counts
          if (shf_done) begin
            state   <= STORE;
            rx_data <= shf_rdata;
            rx_push <= 1'b1;
          end else if (wd == WD_EXP) begin
            state <= IDLE;
            err   <= 1'b1;
            ss_n  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        STORE: begin
          if (cont && gap_cfg == '0) begin
            state    <= LOAD;
            tx_pop   <= 1'b1;
            shf_data <= tx_data;
          end else if (cont) begin
            state <= GAP;
          end else begin
            state <= IDLE;
            ss_n  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        GAP: begin
          if (gap_last && go) begin
            state    <= LOAD;
            tx_pop   <= 1'b1;
            shf_data <= tx_data;
          end else if (gap_last) begin
            state <= IDLE;
            ss_n  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ss_n  <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl: cycle tables plus watchdog and
// mid-frame reset sequences.
module tb_spi_xfer_ctrl;
  import spi_ctrl_pkg::*;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       en;
  logic [3:0] gap_cfg;
  logic [3:0] tx_cnt;
  logic [7:0] tx_data;
  logic       tx_pop;
  logic [3:0] rx_cnt;
  logic       rx_push;
  logic [7:0] rx_data;
  logic       shf_start;
  logic [7:0] shf_data;
  logic       shf_done;
  logic [7:0] shf_rdata;
  logic       ss_n;
  logic       busy;
  logic       err;

  always #5 PCLK = ~PCLK;

  spi_xfer_ctrl dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .en        (en),
    .gap_cfg   (gap_cfg),
    .tx_cnt    (tx_cnt),
    .tx_data   (tx_data),
    .tx_pop    (tx_pop),
    .rx_cnt    (rx_cnt),
    .rx_push   (rx_push),
    .rx_data   (rx_data),
    .shf_start (shf_start),
    .shf_data  (shf_data),
    .shf_done  (shf_done),
    .shf_rdata (shf_rdata),
    .ss_n      (ss_n),
    .busy      (busy),
    .err       (err)
  );

  // {tx_pop, shf_start, rx_push, ss_n, busy, err}
  localparam logic [5:0] C_IDLE  = 6'b000100;
  localparam logic [5:0] C_LOAD  = 6'b100010;
  localparam logic [5:0] C_START = 6'b010010;
  localparam logic [5:0] C_SHIFT = 6'b000010;
  localparam logic [5:0] C_STORE = 6'b001010;
  localparam logic [5:0] C_GAP   = 6'b000010;
  localparam logic [5:0] C_ERR   = 6'b000101;

  typedef struct {
    int         rep;
    logic       en;
    logic [3:0] tx;
    logic [7:0] td;
    logic [3:0] rx;
    logic       dn;
    logic [7:0] rd;
    logic [3:0] gap;
    logic [5:0] ctl;
    logic [7:0] esd;
    logic [7:0] erd;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nbad = 0;

  function automatic logic [5:0] ctl();
    return {tx_pop, shf_start, rx_push, ss_n, busy, err};
  endfunction

  function automatic logic [21:0] outs();
    return {ctl(), shf_data, rx_data};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic add(input int rep, input logic e, input logic [3:0] tx,
                     input logic [7:0] td, input logic [3:0] rx,
                     input logic dn, input logic [7:0] rd,
                     input logic [3:0] gap, input logic [5:0] c,
                     input logic [7:0] esd, input logic [7:0] erd);
    vec_t v;
    v = '{rep, e, tx, td, rx, dn, rd, gap, c, esd, erd};
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    int  k;
    bit  seen_push;
    PRESETn   = 1'b0;
    en        = 1'b0;
    gap_cfg   = '0;
    tx_cnt    = '0;
    tx_data   = '0;
    rx_cnt    = '0;
    shf_done  = 1'b0;
    shf_rdata = '0;

    // single frame, done 10 cycles after start
    add(1,  1, 1, 8'hA5, 0, 0, 8'h00, 0, C_LOAD,  8'hA5, 8'h00);
    add(1,  1, 0, 8'hA5, 0, 0, 8'h00, 0, C_START, 8'hA5, 8'h00);
    add(10, 1, 0, 8'hA5, 0, 0, 8'h00, 0, C_SHIFT, 8'hA5, 8'h00);
    add(1,  1, 0, 8'hA5, 0, 1, 8'h3C, 0, C_STORE, 8'hA5, 8'h3C);
    add(2,  1, 0, 8'hA5, 0, 0, 8'h00, 0, C_IDLE,  8'hA5, 8'h3C);
    // burst of 3, no gap
    add(1, 1, 3, 8'h11, 0, 0, 8'h00, 0, C_LOAD,  8'h11, 8'h3C);
    add(1, 1, 2, 8'h22, 0, 0, 8'h00, 0, C_START, 8'h11, 8'h3C);
    add(1, 1, 2, 8'h22, 0, 1, 8'hE1, 0, C_STORE, 8'h11, 8'hE1);
    add(1, 1, 2, 8'h22, 0, 0, 8'h00, 0, C_LOAD,  8'h22, 8'hE1);
    add(1, 1, 1, 8'h33, 0, 0, 8'h00, 0, C_START, 8'h22, 8'hE1);
    add(1, 1, 1, 8'h33, 0, 1, 8'hE2, 0, C_STORE, 8'h22, 8'hE2);
    add(1, 1, 1, 8'h33, 0, 0, 8'h00, 0, C_LOAD,  8'h33, 8'hE2);
    add(1, 1, 0, 8'h33, 0, 0, 8'h00, 0, C_START, 8'h33, 8'hE2);
    add(1, 1, 0, 8'h33, 0, 1, 8'hE3, 0, C_STORE, 8'h33, 8'hE3);
    add(1, 1, 0, 8'h33, 0, 0, 8'h00, 0, C_IDLE,  8'h33, 8'hE3);
    // two frames with a 3-cycle gap
    add(1, 1, 2, 8'h44, 0, 0, 8'h00, 3, C_LOAD,  8'h44, 8'hE3);
    add(1, 1, 1, 8'h55, 0, 0, 8'h00, 3, C_START, 8'h44, 8'hE3);
    add(1, 1, 1, 8'h55, 0, 1, 8'h5A, 3, C_STORE, 8'h44, 8'h5A);
    add(3, 1, 1, 8'h55, 0, 0, 8'h00, 3, C_GAP,   8'h44, 8'h5A);
    add(1, 1, 1, 8'h55, 0, 0, 8'h00, 3, C_LOAD,  8'h55, 8'h5A);
    add(1, 1, 0, 8'h55, 0, 0, 8'h00, 3, C_START, 8'h55, 8'h5A);
    add(1, 1, 0, 8'h55, 0, 1, 8'h5B, 3, C_STORE, 8'h55, 8'h5B);
    add(1, 1, 0, 8'h55, 0, 0, 8'h00, 3, C_IDLE,  8'h55, 8'h5B);
    // RX nearly full: stop after one frame, resume when space returns
    add(1, 1, 2, 8'h66, 7, 0, 8'h00, 0, C_LOAD,  8'h66, 8'h5B);
    add(1, 1, 1, 8'h77, 7, 0, 8'h00, 0, C_START, 8'h66, 8'h5B);
    add(1, 1, 1, 8'h77, 7, 1, 8'h6A, 0, C_STORE, 8'h66, 8'h6A);
    add(1, 1, 1, 8'h77, 7, 0, 8'h00, 0, C_IDLE,  8'h66, 8'h6A);
    add(3, 1, 1, 8'h77, 8, 0, 8'h00, 0, C_IDLE,  8'h66, 8'h6A);
    add(1, 1, 1, 8'h77, 7, 0, 8'h00, 0, C_LOAD,  8'h77, 8'h6A);
    add(1, 1, 0, 8'h77, 7, 0, 8'h00, 0, C_START, 8'h77, 8'h6A);
    add(1, 1, 0, 8'h77, 7, 1, 8'h7B, 0, C_STORE, 8'h77, 8'h7B);
    add(1, 1, 0, 8'h77, 7, 0, 8'h00, 0, C_IDLE,  8'h77, 8'h7B);
    // en dropped mid-frame: frame completes, then idle
    add(1, 1, 2, 8'h88, 0, 0, 8'h00, 0, C_LOAD,  8'h88, 8'h7B);
    add(1, 0, 1, 8'h99, 0, 0, 8'h00, 0, C_START, 8'h88, 8'h7B);
    add(2, 0, 1, 8'h99, 0, 0, 8'h00, 0, C_SHIFT, 8'h88, 8'h7B);
    add(1, 0, 1, 8'h99, 0, 1, 8'h8C, 0, C_STORE, 8'h88, 8'h8C);
    add(2, 0, 1, 8'h99, 0, 0, 8'h00, 0, C_IDLE,  8'h88, 8'h8C);

    repeat (2) @(posedge PCLK);
    #1;
    chk("reset_state", 32'(outs()), 32'({C_IDLE, 16'h0000}));
    PRESETn = 1'b1;

    foreach (tbl[i]) begin
      en        = tbl[i].en;
      tx_cnt    = tbl[i].tx;
      tx_data   = tbl[i].td;
      rx_cnt    = tbl[i].rx;
      shf_done  = tbl[i].dn;
      shf_rdata = tbl[i].rd;
      gap_cfg   = tbl[i].gap;
      for (int r = 0; r < tbl[i].rep; r++) begin
        tick();
        chk($sformatf("row%0d.%0d", i, r), 32'(outs()),
            32'({tbl[i].ctl, tbl[i].esd, tbl[i].erd}));
      end
    end

    // watchdog: shifter never completes
    en = 1'b1; tx_cnt = 1; tx_data = 8'h9D; rx_cnt = 0;
    shf_done = 1'b0; gap_cfg = 0;
    tick();
    chk("wd_load", 32'(ctl()), 32'(C_LOAD));
    tx_cnt = 0;
    tick();
    chk("wd_start", 32'(ctl()), 32'(C_START));
    k = 0;
    seen_push = 1'b0;
    while (!err && k < 400) begin
      tick();
      k++;
      if (rx_push) seen_push = 1'b1;
    end
    chk("wd_cycles", k, TMO_MAX);
    chk("wd_err", 32'(ctl()), 32'(C_ERR));
    chk("wd_nopush", 32'(seen_push), 0);
    tick();
    chk("wd_pulse", 32'(ctl()), 32'(C_IDLE));

    // asynchronous reset in the middle of SHIFT
    tx_cnt = 1; tx_data = 8'hC3;
    tick();
    chk("rs_load", 32'(ctl()), 32'(C_LOAD));
    tx_cnt = 0;
    tick();
    chk("rs_start", 32'(ctl()), 32'(C_START));
    tick();
    PRESETn = 1'b0;
    #1;
    chk("rs_async", 32'(outs()), 32'({C_IDLE, 16'h0000}));
    shf_done = 1'b1; shf_rdata = 8'hFF;
    tick();
    chk("rs_hold", 32'(outs()), 32'({C_IDLE, 16'h0000}));
    PRESETn = 1'b1;
    shf_done = 1'b0;
    tx_cnt = 1; tx_data = 8'hD4;
    tick();
    chk("rs_f_load", 32'(outs()), 32'({C_LOAD, 8'hD4, 8'h00}));
    tx_cnt = 0;
    tick();
    chk("rs_f_start", 32'(outs()), 32'({C_START, 8'hD4, 8'h00}));
    shf_done = 1'b1; shf_rdata = 8'h4D;
    tick();
    chk("rs_f_store", 32'(outs()), 32'({C_STORE, 8'hD4, 8'h4D}));
    shf_done = 1'b0;
    tick();
    chk("rs_f_idle", 32'(outs()), 32'({C_IDLE, 8'hD4, 8'h4D}));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
